d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop_pkg.sv | 6 +
 rtl/d_flip_flop_if.sv | 16 +
 rtl/d_flip_flop.sv | 28 ++
 tb/tb_d_flip_flop.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the d_flip_flop storage cell and its bus interface.
package d_flip_flop_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/d_flip_flop_if.sv
// Data bus of the d_flip_flop cell: D in, true Q and complementary q out.
interface d_flip_flop_if
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned WIDTH = DFF_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] q;

  // master supplies data and observes the register; slave is the register itself
  modport master (output D, input Q, input q);
  modport slave  (input D, output Q, output q);

endinterface

// File: rtl/d_flip_flop.sv
// Positive-edge D register with asynchronous active-high reset and a
// complementary output derived combinationally from the single stored word.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  d_flip_flop_if.slave bus
);

  logic [WIDTH-1:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else begin
      state <= bus.D;
    end
  end

  // q is not a second register, so it tracks Q even while reset is held
  assign bus.Q = state;
  assign bus.q = ~state;

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: a 1-bit instance and an 8-bit instance
// with a non-zero reset value, checked against expectations computed here.
module tb_d_flip_flop;

  localparam logic [7:0] RV8 = 8'hA5;

  logic clk  = 1'b0;
  bit   run  = 1'b0;
  logic rst1 = 1'b0;
  logic rst8 = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  d_flip_flop_if #(.WIDTH(1)) bus1 ();
  d_flip_flop_if #(.WIDTH(8)) bus8 ();

  d_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  // clock stays idle until the bench starts it; period 20 ns
  always #10 if (run) clk = ~clk;

  task automatic test_reset;
    logic [0:0] e1;
    logic [7:0] e8;
    e1 = 1'b0;
    e8 = RV8;
    rst1 = 1'b1;
    rst8 = 1'b1;
    bus1.D = 1'b1;
    bus8.D = 8'hFF;
    #1;
    vectors++;
    if (bus1.Q !== e1 || bus1.q !== ~e1) begin
      miscompares++;
      $display("FAIL reset_idle_w1: Q=%b q=%b, expected Q=%b q=%b", bus1.Q, bus1.q, e1, ~e1);
    end
    vectors++;
    if (bus8.Q !== e8 || bus8.q !== ~e8) begin
      miscompares++;
      $display("FAIL reset_idle_w8: Q=%h q=%h, expected Q=%h q=%h", bus8.Q, bus8.q, e8, ~e8);
    end
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== e1 || bus1.q !== ~e1) begin
      miscompares++;
      $display("FAIL reset_held_edges: Q=%b q=%b, expected Q=%b q=%b", bus1.Q, bus1.q, e1, ~e1);
    end
    @(negedge clk);
    rst1 = 1'b0;
    rst8 = 1'b0;
    #1;
    vectors++;
    if (bus1.Q !== e1) begin
      miscompares++;
      $display("FAIL reset_release_no_action: Q=%b, expected Q=%b", bus1.Q, e1);
    end
  endtask

  task automatic test_capture;
    bus1.D = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b0 || bus1.q !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_edge1: Q=%b q=%b, expected Q=0 q=1", bus1.Q, bus1.q);
    end
    @(negedge clk);
    bus1.D = 1'b1;
    #1;
    vectors++;
    if (bus1.Q !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_before_edge2: Q=%b, expected Q=0", bus1.Q);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b1 || bus1.q !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_edge2: Q=%b q=%b, expected Q=1 q=0", bus1.Q, bus1.q);
    end
  endtask

  task automatic test_hold;
    #2 bus1.D = 1'b0;
    #1;
    vectors++;
    if (bus1.Q !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_high_phase: Q=%b, expected Q=1", bus1.Q);
    end
    @(negedge clk);
    #2 bus1.D = 1'b1;
    #2 bus1.D = 1'b0;
    #2 bus1.D = 1'b1;
    #1;
    vectors++;
    if (bus1.Q !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_low_phase: Q=%b, expected Q=1", bus1.Q);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b1 || bus1.q !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_next_edge: Q=%b q=%b, expected Q=1 q=0", bus1.Q, bus1.q);
    end
    @(negedge clk);
    bus1.D = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b0 || bus1.q !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_then_load0: Q=%b q=%b, expected Q=0 q=1", bus1.Q, bus1.q);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus1.D = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b1) begin
      miscompares++;
      $display("FAIL async_preload: Q=%b, expected Q=1", bus1.Q);
    end
    #4 rst1 = 1'b1;
    #1;
    vectors++;
    if (bus1.Q !== 1'b0 || bus1.q !== 1'b1) begin
      miscompares++;
      $display("FAIL async_assert_midcycle: Q=%b q=%b, expected Q=0 q=1", bus1.Q, bus1.q);
    end
    #2 rst1 = 1'b0;
    #1;
    vectors++;
    if (bus1.Q !== 1'b0) begin
      miscompares++;
      $display("FAIL async_release_no_action: Q=%b, expected Q=0", bus1.Q);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b0) begin
      miscompares++;
      $display("FAIL async_falling_edge: Q=%b, expected Q=0", bus1.Q);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.Q !== 1'b1 || bus1.q !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reload: Q=%b q=%b, expected Q=1 q=0", bus1.Q, bus1.q);
    end
  endtask

  task automatic test_param;
    @(negedge clk);
    rst8 = 1'b1;
    bus8.D = 8'h3C;
    #1;
    vectors++;
    if (bus8.Q !== 8'hA5 || bus8.q !== 8'h5A) begin
      miscompares++;
      $display("FAIL param_reset: Q=%h q=%h, expected Q=a5 q=5a", bus8.Q, bus8.q);
    end
    #4 rst8 = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus8.Q !== 8'h3C || bus8.q !== 8'hC3) begin
      miscompares++;
      $display("FAIL param_load: Q=%h q=%h, expected Q=3c q=c3", bus8.Q, bus8.q);
    end
  endtask

  // Random data and reset pulses; expected state follows the capture/reset
  // rules directly: reset value if rst is high at the edge, otherwise D.
  task automatic test_random;
    logic [0:0] m1, e1, d1;
    logic [7:0] m8, e8, d8;
    bit p1, p8, h1, h8, known;
    m1 = '0;
    m8 = '0;
    known = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      bus1.D = d1;
      bus8.D = d8;
      p1 = ($urandom_range(0, 5) == 0);
      p8 = ($urandom_range(0, 5) == 0);
      h1 = 1'($urandom_range(0, 1));
      h8 = 1'($urandom_range(0, 1));
      #2;
      if (p1) rst1 = 1'b1;
      if (p8) rst8 = 1'b1;
      #1;
      e1 = p1 ? 1'b0 : m1;
      e8 = p8 ? RV8 : m8;
      if (p1 || known) begin
        vectors++;
        if (bus1.Q !== e1 || bus1.q !== ~e1) begin
          miscompares++;
          $display("FAIL rand_low_w1[%0d]: Q=%b q=%b, expected Q=%b q=%b", i, bus1.Q, bus1.q, e1, ~e1);
        end
      end
      if (p8 || known) begin
        vectors++;
        if (bus8.Q !== e8 || bus8.q !== ~e8) begin
          miscompares++;
          $display("FAIL rand_low_w8[%0d]: Q=%h q=%h, expected Q=%h q=%h", i, bus8.Q, bus8.q, e8, ~e8);
        end
      end
      #2;
      if (p1 && !h1) rst1 = 1'b0;
      if (p8 && !h8) rst8 = 1'b0;
      e1 = (p1 && h1) ? 1'b0 : d1;
      e8 = (p8 && h8) ? RV8 : d8;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.Q !== e1 || bus1.q !== ~e1) begin
        miscompares++;
        $display("FAIL rand_edge_w1[%0d]: Q=%b q=%b, expected Q=%b q=%b", i, bus1.Q, bus1.q, e1, ~e1);
      end
      vectors++;
      if (bus8.Q !== e8 || bus8.q !== ~e8) begin
        miscompares++;
        $display("FAIL rand_edge_w8[%0d]: Q=%h q=%h, expected Q=%h q=%h", i, bus8.Q, bus8.q, e8, ~e8);
      end
      #2;
      rst1 = 1'b0;
      rst8 = 1'b0;
      bus1.D = 1'($urandom);
      bus8.D = 8'($urandom);
      #1;
      vectors++;
      if (bus1.Q !== e1 || bus1.q !== ~e1 || bus8.Q !== e8 || bus8.q !== ~e8) begin
        miscompares++;
        $display("FAIL rand_high_phase[%0d]: Q1=%b q1=%b Q8=%h q8=%h, expected Q1=%b q1=%b Q8=%h q8=%h",
                 i, bus1.Q, bus1.q, bus8.Q, bus8.q, e1, ~e1, e8, ~e8);
      end
      m1 = e1;
      m8 = e8;
      known = 1'b1;
    end
  endtask

  initial begin
    bus1.D = '0;
    bus8.D = '0;
    test_reset();
    test_capture();
    test_hold();
    test_async_reset();
    test_param();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
